// File: rtl/msu_prefetch_ctrl.sv
// MSU-1 register window with a data-track prefetch FIFO and one-outstanding fetch engine.
// Optional volume fading is enabled by defining MSU_FADE_EN.
`timescale 1ns/1ps
module msu_prefetch_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int FADE_DIV   = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic        SYSCLKF_CE,
  input  logic [23:0] ADDR,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        MSU_SEL,
  output logic [15:0] track_num,
  output logic        track_request,
  input  logic        track_mounting,
  output logic [7:0]  volume,
  input  logic        status_track_missing,
  output logic        status_audio_repeat,
  output logic        status_audio_playing,
  input  logic        audio_stop,
  output logic [31:0] data_addr,
  output logic        data_seek,
  output logic        data_req,
  input  logic [7:0]  data,
  input  logic        data_ack
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FADE_DIV < 1) begin : g_param_check
    $error("msu_prefetch_ctrl: FIFO_DEPTH must be a power of two in 2..64 and FADE_DIV >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  fetch_state_t   state_r;
  logic [23:0]    seek_r;
  logic [7:0]     track_lsb_r;
  logic           mount_d_r;
  logic           rd_d_r;
  logic           stale_r;
  logic [7:0]     fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CW-1:0]  count_r;

  logic           wr_s;
  logic [7:0]     wr_reg_s;
  logic           seek_s;
  logic           rd_s;
  logic           fifo_empty_s;
  logic           fifo_full_s;
  logic           ack_ok_s;
  logic           push_s;
  logic           pop_s;
  logic [7:0]     status_s;
  logic           addr_unused_s;

  assign MSU_SEL       = ENABLE & ~ADDR[22] & (ADDR[15:4] == 12'h200) & ~ADDR[3];
  assign wr_s          = MSU_SEL & SYSCLKF_CE & ~WR_N;
  assign wr_reg_s      = wr_s ? (8'd1 << ADDR[2:0]) : 8'd0;
  assign seek_s        = wr_reg_s[3];
  assign rd_s          = MSU_SEL & ~RD_N & (ADDR[2:0] == 3'd1);
  assign fifo_empty_s  = (count_r == {CW{1'b0}});
  assign fifo_full_s   = (count_r == DEPTH_C);
  // A stale ack never reaches WAIT, but the guard keeps the push path honest.
  assign ack_ok_s      = data_ack & (state_r == ST_WAIT) & ~stale_r;
  assign push_s        = ack_ok_s & ~seek_s;
  assign pop_s         = rd_d_r & ~rd_s & ~fifo_empty_s & ~seek_s;
  assign status_s      = {data_seek | fifo_empty_s, track_request, status_audio_repeat,
                          status_audio_playing, status_track_missing, 3'b010};
  assign addr_unused_s = ^{ADDR[23], ADDR[21:16]};

  // Bus-side registers: seek/track shadows, track request and playback flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      seek_r               <= 24'h000000;
      track_lsb_r          <= 8'h00;
      track_num            <= 16'h0000;
      track_request        <= 1'b0;
      mount_d_r            <= 1'b0;
      rd_d_r               <= 1'b0;
      status_audio_repeat  <= 1'b0;
      status_audio_playing <= 1'b0;
    end else begin
      mount_d_r <= track_mounting;
      rd_d_r    <= rd_s;
      if (wr_reg_s[0]) seek_r[7:0]   <= DIN;
      if (wr_reg_s[1]) seek_r[15:8]  <= DIN;
      if (wr_reg_s[2]) seek_r[23:16] <= DIN;
      if (wr_reg_s[4]) track_lsb_r   <= DIN;
      if (wr_reg_s[5]) begin
        track_num     <= {DIN, track_lsb_r};
        track_request <= 1'b1;
      end else if (mount_d_r && !track_mounting) begin
        track_request <= 1'b0;
      end
      if (wr_reg_s[7]) begin
        status_audio_repeat  <= DIN[1];
        status_audio_playing <= DIN[0];
      end else if (audio_stop) begin
        status_audio_playing <= 1'b0;
      end
    end
  end

`ifdef MSU_FADE_EN
  logic [7:0]  vol_target_r;
  logic [31:0] fade_cnt_r;

  // Volume ramps one step per FADE_DIV cycles toward the latest target.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      volume       <= 8'h00;
      vol_target_r <= 8'h00;
      fade_cnt_r   <= 32'd0;
    end else if (wr_reg_s[6]) begin
      vol_target_r <= DIN;
      fade_cnt_r   <= 32'd0;
    end else if (fade_cnt_r == 32'(FADE_DIV - 1)) begin
      fade_cnt_r <= 32'd0;
      if (volume < vol_target_r) begin
        volume <= volume + 8'd1;
      end else if (volume > vol_target_r) begin
        volume <= volume - 8'd1;
      end
    end else begin
      fade_cnt_r <= fade_cnt_r + 32'd1;
    end
  end
`else
  // Volume takes the written value directly.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      volume <= 8'h00;
    end else if (wr_reg_s[6]) begin
      volume <= DIN;
    end
  end
`endif

  // Fetch engine: one request in flight; a seek retargets and orphans any open request.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      data_req  <= 1'b0;
      data_addr <= 32'h00000000;
      data_seek <= 1'b0;
      stale_r   <= 1'b0;
    end else if (seek_s) begin
      state_r   <= ST_IDLE;
      data_req  <= 1'b0;
      data_addr <= {DIN, seek_r};
      data_seek <= 1'b1;
      stale_r   <= (state_r == ST_REQ) | ((state_r == ST_WAIT) & ~data_ack) | (stale_r & ~data_ack);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (stale_r) begin
            data_req <= 1'b0;
            if (data_ack) stale_r <= 1'b0;
          end else if (!fifo_full_s) begin
            state_r  <= ST_REQ;
            data_req <= 1'b1;
          end else begin
            data_req <= 1'b0;
          end
        end
        ST_REQ: begin
          state_r  <= ST_WAIT;
          data_req <= 1'b0;
        end
        ST_WAIT: begin
          data_req <= 1'b0;
          if (ack_ok_s) begin
            state_r   <= ST_IDLE;
            data_addr <= data_addr + 32'd1;
            data_seek <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping; a seek flushes regardless of a simultaneous push or pop.
  always_ff @(posedge CLK) begin
    if (!RST_N || seek_s) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PW'(1);
      if (pop_s)  head_r <= head_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK) begin
    if (push_s) fifo_mem_r[tail_r] <= data;
  end

  // Registered read mux.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DOUT <= 8'h00;
    end else begin
      case (ADDR[2:0])
        3'd0:    DOUT <= status_s;
        3'd1:    DOUT <= fifo_empty_s ? 8'h00 : fifo_mem_r[head_r];
        3'd2:    DOUT <= 8'h53;
        3'd3:    DOUT <= 8'h2D;
        3'd4:    DOUT <= 8'h4D;
        3'd5:    DOUT <= 8'h53;
        3'd6:    DOUT <= 8'h55;
        3'd7:    DOUT <= 8'h32;
        default: DOUT <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_prefetch_ctrl.sv
// Directed self-checking bench for msu_prefetch_ctrl with a delayed-ack data responder.
`timescale 1ns/1ps
module tb_msu_prefetch_ctrl;

`ifdef MSU_FADE_EN
  localparam int FDIV = 4;
`else
  localparam int FDIV = 1024;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENABLE = 1'b1;
  logic        RD_N = 1'b1;
  logic        WR_N = 1'b1;
  logic        SYSCLKF_CE = 1'b0;
  logic [23:0] ADDR = 24'h002000;
  logic [7:0]  DIN = 8'h00;
  logic [7:0]  DOUT;
  logic        MSU_SEL;
  logic [15:0] track_num;
  logic        track_request;
  logic        track_mounting = 1'b0;
  logic [7:0]  volume;
  logic        status_track_missing = 1'b0;
  logic        status_audio_repeat;
  logic        status_audio_playing;
  logic        audio_stop = 1'b0;
  logic [31:0] data_addr;
  logic        data_seek;
  logic        data_req;
  logic [7:0]  data;
  logic        data_ack;

  int vectors = 0;
  int miscompares = 0;

  logic       resp_en = 1'b0;
  int         resp_dly = 1;
  logic       resp_ack = 1'b0;
  logic [7:0] resp_data = 8'h00;
  logic [7:0] resp_seed = 8'h00;
  int         ack_cnt = 0;
  int         req_cnt = 0;
  logic       tb_ack = 1'b0;
  logic [7:0] tb_data = 8'h00;

  assign data_ack = resp_ack | tb_ack;
  assign data     = tb_ack ? tb_data : resp_data;

  always #5 CLK = ~CLK;

  msu_prefetch_ctrl #(.FIFO_DEPTH(8), .FADE_DIV(FDIV)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .RD_N(RD_N), .WR_N(WR_N),
    .SYSCLKF_CE(SYSCLKF_CE), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .MSU_SEL(MSU_SEL),
    .track_num(track_num), .track_request(track_request), .track_mounting(track_mounting),
    .volume(volume), .status_track_missing(status_track_missing),
    .status_audio_repeat(status_audio_repeat), .status_audio_playing(status_audio_playing),
    .audio_stop(audio_stop), .data_addr(data_addr), .data_seek(data_seek),
    .data_req(data_req), .data(data), .data_ack(data_ack)
  );

  // Data source: answers each request resp_dly cycles later with seed+index.
  initial forever begin
    @(negedge CLK);
    if (resp_en && data_req) begin
      repeat (resp_dly) @(negedge CLK);
      resp_data = resp_seed + ack_cnt[7:0];
      resp_ack  = 1'b1;
      @(negedge CLK);
      resp_ack = 1'b0;
      ack_cnt++;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (data_req) req_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_write(input logic [2:0] r, input logic [7:0] v);
    @(negedge CLK);
    ADDR = {21'h000400, r}; DIN = v; WR_N = 1'b0; SYSCLKF_CE = 1'b1;
    @(negedge CLK);
    WR_N = 1'b1; SYSCLKF_CE = 1'b0; ADDR = 24'h002000;
  endtask

  task automatic bus_read(input logic [2:0] r, output logic [7:0] v);
    @(negedge CLK);
    ADDR = {21'h000400, r}; RD_N = 1'b0;
    @(negedge CLK);
    v = DOUT; RD_N = 1'b1; ADDR = 24'h002000;
    @(negedge CLK);
  endtask

  task automatic wait_acks(input int target, input int limit, input string name);
    int t = 0;
    while (ack_cnt < target && t < limit) begin
      @(negedge CLK);
      t++;
    end
    vectors++;
    if (ack_cnt < target) begin
      miscompares++;
      $display("FAIL %s timeout: acks %0d, required %0d", name, ack_cnt, target);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(3);
    vectors++;
    if ({DOUT, track_num, track_request, volume, status_audio_repeat, status_audio_playing,
         data_addr, data_seek, data_req} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: DOUT=%h trk=%h req=%b vol=%h addr=%h seek=%b dreq=%b, required all 0",
               DOUT, track_num, track_request, volume, data_addr, data_seek, data_req);
    end
    RST_N = 1'b1; resp_en = 1'b1; resp_dly = 1; resp_seed = 8'h10;
    wait_acks(8, 200, "initial_fill");
    tick(10);
    vectors++;
    if (data_addr !== 32'd8) begin
      miscompares++; $display("FAIL fill_addr: got %h, required %h", data_addr, 32'd8);
    end
    vectors++;
    if (req_cnt !== 8) begin
      miscompares++; $display("FAIL fill_reqs: got %0d, required 8", req_cnt);
    end
    vectors++;
    if (DOUT !== 8'h02) begin
      miscompares++; $display("FAIL status_full: got %h, required 02", DOUT);
    end
  endtask

  task automatic test_decode();
    logic [23:0] a_tab [9] = '{24'h002000, 24'h002007, 24'h802005, 24'h402000, 24'h002008,
                               24'h002100, 24'h002000, 24'h7E2001, 24'h003000};
    logic        e_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        x_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      ADDR = a_tab[i]; ENABLE = e_tab[i];
      #1;
      vectors++;
      if (MSU_SEL !== x_tab[i]) begin
        miscompares++;
        $display("FAIL decode[%0d] addr=%h en=%b: got %b, required %b", i, a_tab[i], e_tab[i], MSU_SEL, x_tab[i]);
      end
    end
    @(negedge CLK);
    ADDR = 24'h002000; ENABLE = 1'b1;
  endtask

  task automatic test_id();
    logic [7:0] id_tab [8] = '{8'h00, 8'h00, 8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h32};
    logic [7:0] v;
    for (int i = 2; i < 8; i++) begin
      bus_read(3'(i), v);
      vectors++;
      if (v !== id_tab[i]) begin
        miscompares++; $display("FAIL id_reg%0d: got %h, required %h", i, v, id_tab[i]);
      end
    end
  endtask

  task automatic test_seek();
    int rb, ab;
    resp_dly = 2;
    rb = req_cnt; ab = ack_cnt;
    bus_write(3'd0, 8'h00); bus_write(3'd1, 8'h10); bus_write(3'd2, 8'h00); bus_write(3'd3, 8'h00);
    vectors++;
    if (data_seek !== 1'b1 || data_addr !== 32'h00001000) begin
      miscompares++; $display("FAIL seek_load: seek=%b addr=%h, required 1 00001000", data_seek, data_addr);
    end
    @(negedge CLK);
    vectors++;
    if (DOUT !== 8'h82) begin
      miscompares++; $display("FAIL seek_status: got %h, required 82", DOUT);
    end
    wait_acks(ab + 1, 50, "seek_first_ack");
    tick(2);
    vectors++;
    if (DOUT !== 8'h02) begin
      miscompares++; $display("FAIL seek_status_after_push: got %h, required 02", DOUT);
    end
    wait_acks(ab + 8, 200, "seek_fill");
    tick(10);
    vectors++;
    if (data_addr !== 32'h00001008 || data_seek !== 1'b0) begin
      miscompares++; $display("FAIL seek_end: addr=%h seek=%b, required 00001008 0", data_addr, data_seek);
    end
    vectors++;
    if (req_cnt - rb !== 8) begin
      miscompares++; $display("FAIL seek_reqs: got %0d, required 8", req_cnt - rb);
    end
  endtask

  task automatic test_fifo_order();
    int rb, ab;
    logic [7:0] v;
    resp_dly = 1;
    resp_seed = 8'hA0 - ack_cnt[7:0];
    ab = ack_cnt;
    bus_write(3'd0, 8'h00); bus_write(3'd1, 8'h00); bus_write(3'd2, 8'h00); bus_write(3'd3, 8'h00);
    wait_acks(ab + 8, 200, "fifo_fill");
    tick(10);
    vectors++;
    if (data_addr !== 32'd8) begin
      miscompares++; $display("FAIL fifo_fill_addr: got %h, required 00000008", data_addr);
    end
    rb = req_cnt;
    for (int i = 0; i < 8; i++) begin
      bus_read(3'd1, v);
      vectors++;
      if (v !== 8'hA0 + 8'(i)) begin
        miscompares++; $display("FAIL fifo_read%0d: got %h, required %h", i, v, 8'hA0 + 8'(i));
      end
    end
    tick(20);
    vectors++;
    if (req_cnt - rb !== 8) begin
      miscompares++; $display("FAIL fifo_refills: got %0d, required 8", req_cnt - rb);
    end
    bus_read(3'd1, v);
    vectors++;
    if (v !== 8'hA8) begin
      miscompares++; $display("FAIL fifo_read9: got %h, required A8", v);
    end
    tick(10);
    vectors++;
    if (req_cnt - rb !== 9) begin
      miscompares++; $display("FAIL fifo_refill9: got %0d, required 9", req_cnt - rb);
    end
  endtask

  task automatic test_stale_ack();
    int rb, t;
    logic [7:0] v;
    tick(10);
    resp_en = 1'b0;
    rb = req_cnt;
    bus_read(3'd1, v);
    vectors++;
    if (v !== 8'hA9) begin
      miscompares++; $display("FAIL stale_pre_read: got %h, required A9", v);
    end
    tick(4);
    vectors++;
    if (req_cnt - rb !== 1) begin
      miscompares++; $display("FAIL stale_refill_req: got %0d, required 1", req_cnt - rb);
    end
    bus_write(3'd0, 8'h00); bus_write(3'd1, 8'h20); bus_write(3'd2, 8'h00); bus_write(3'd3, 8'h00);
    vectors++;
    if (data_addr !== 32'h00002000 || data_seek !== 1'b1) begin
      miscompares++; $display("FAIL stale_seek: addr=%h seek=%b, required 00002000 1", data_addr, data_seek);
    end
    rb = req_cnt;
    tick(4);
    vectors++;
    if (req_cnt - rb !== 0) begin
      miscompares++; $display("FAIL stale_hold: got %0d reqs, required 0", req_cnt - rb);
    end
    @(negedge CLK); tb_data = 8'h55; tb_ack = 1'b1;
    @(negedge CLK); tb_ack = 1'b0;
    vectors++;
    if (data_addr !== 32'h00002000) begin
      miscompares++; $display("FAIL stale_no_incr: got %h, required 00002000", data_addr);
    end
    t = 0;
    while (data_req !== 1'b1 && t < 8) begin
      @(negedge CLK);
      t++;
    end
    vectors++;
    if (data_req !== 1'b1) begin
      miscompares++; $display("FAIL stale_new_req: data_req=%b, required 1", data_req);
    end
    tick(2);
    bus_read(3'd1, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++; $display("FAIL stale_not_pushed: got %h, required 00", v);
    end
    @(negedge CLK); tb_data = 8'h66; tb_ack = 1'b1; resp_en = 1'b1;
    @(negedge CLK); tb_ack = 1'b0;
    vectors++;
    if (data_addr !== 32'h00002001 || data_seek !== 1'b0) begin
      miscompares++; $display("FAIL stale_fresh_push: addr=%h seek=%b, required 00002001 0", data_addr, data_seek);
    end
    bus_read(3'd1, v);
    vectors++;
    if (v !== 8'h66) begin
      miscompares++; $display("FAIL stale_fresh_data: got %h, required 66", v);
    end
  endtask

  task automatic test_track();
    bus_write(3'd4, 8'h02); bus_write(3'd5, 8'h01);
    vectors++;
    if (track_num !== 16'h0102 || track_request !== 1'b1) begin
      miscompares++; $display("FAIL track_load: num=%h req=%b, required 0102 1", track_num, track_request);
    end
    status_track_missing = 1'b1;
    tick(2);
    vectors++;
    if (DOUT[6:0] !== 7'h4A) begin
      miscompares++; $display("FAIL track_status: got %h, required 4A", DOUT[6:0]);
    end
    status_track_missing = 1'b0;
    @(negedge CLK); track_mounting = 1'b1;
    tick(2);
    vectors++;
    if (track_request !== 1'b1) begin
      miscompares++; $display("FAIL track_mount_rise: got %b, required 1", track_request);
    end
    @(negedge CLK); track_mounting = 1'b0;
    @(negedge CLK);
    vectors++;
    if (track_request !== 1'b0) begin
      miscompares++; $display("FAIL track_mount_fall: got %b, required 0", track_request);
    end
  endtask

  task automatic test_audio();
    bus_write(3'd6, 8'h03);
`ifdef MSU_FADE_EN
    vectors++;
    if (volume !== 8'h00) begin
      miscompares++; $display("FAIL fade_start: got %h, required 00", volume);
    end
    for (int k = 1; k < 4; k++) begin
      tick(4);
      vectors++;
      if (volume !== 8'(k)) begin
        miscompares++; $display("FAIL fade_step%0d: got %h, required %h", k, volume, 8'(k));
      end
    end
`else
    vectors++;
    if (volume !== 8'h03) begin
      miscompares++; $display("FAIL volume_direct: got %h, required 03", volume);
    end
`endif
    bus_write(3'd7, 8'h03);
    vectors++;
    if ({status_audio_repeat, status_audio_playing} !== 2'b11) begin
      miscompares++; $display("FAIL audio_set: got %b, required 11", {status_audio_repeat, status_audio_playing});
    end
    @(negedge CLK); audio_stop = 1'b1;
    @(negedge CLK); audio_stop = 1'b0;
    vectors++;
    if ({status_audio_repeat, status_audio_playing} !== 2'b10) begin
      miscompares++; $display("FAIL audio_stop: got %b, required 10", {status_audio_repeat, status_audio_playing});
    end
    @(negedge CLK);
    ADDR = 24'h002007; DIN = 8'h01; WR_N = 1'b0; SYSCLKF_CE = 1'b1; audio_stop = 1'b1;
    @(negedge CLK);
    WR_N = 1'b1; SYSCLKF_CE = 1'b0; audio_stop = 1'b0; ADDR = 24'h002000;
    vectors++;
    if ({status_audio_repeat, status_audio_playing} !== 2'b01) begin
      miscompares++; $display("FAIL audio_write_priority: got %b, required 01", {status_audio_repeat, status_audio_playing});
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] v;
    tick(30);
    resp_en = 1'b0;
    bus_read(3'd1, v);
    tick(4);
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({DOUT, track_num, track_request, volume, status_audio_repeat, status_audio_playing,
         data_addr, data_seek, data_req} !== 69'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: DOUT=%h trk=%h req=%b vol=%h addr=%h seek=%b dreq=%b, required all 0",
               DOUT, track_num, track_request, volume, data_addr, data_seek, data_req);
    end
    tb_data = 8'h77; tb_ack = 1'b1;
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK); tb_ack = 1'b0;
    tick(4);
    vectors++;
    if (data_addr !== 32'h00000000) begin
      miscompares++; $display("FAIL midreset_addr: got %h, required 00000000", data_addr);
    end
    bus_read(3'd1, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++; $display("FAIL midreset_stray_ack: got %h, required 00", v);
    end
    bus_read(3'd0, v);
    vectors++;
    if (v !== 8'h82) begin
      miscompares++; $display("FAIL midreset_status: got %h, required 82", v);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_id();
    test_seek();
    test_fifo_order();
    test_stale_ack();
    test_track();
    test_audio();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msu_prefetch_ctrl.md
MSU_PREFETCH_CTRL -- requirements
Module: msu_prefetch_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, data-track prefetch FIFO entries; power of two, 2..64.
REQ-002 Parameter FADE_DIV, default 1024, CLK cycles per volume fade step; used only when MSU_FADE_EN is defined.
REQ-003 CLK  in  1  system clock; single clock domain.
REQ-004 RST_N  in  1  synchronous, active-low reset.
REQ-005 ENABLE  in  1  block enable; gates MSU_SEL.
REQ-006 RD_N, WR_N  in  1 each  SNES bus strobes, active low.
REQ-007 SYSCLKF_CE  in  1  write-qualify clock enable.
REQ-008 ADDR  in  24  SNES address; DIN  in  8  write data.
REQ-009 DOUT  out  8  read data, registered; MSU_SEL  out  1  window decode.
REQ-010 track_num  out  16; track_request  out  1; track_mounting  in  1.
REQ-011 volume  out  8; status_track_missing  in  1; status_audio_repeat, status_audio_playing  out  1 each; audio_stop  in  1.
REQ-012 data_addr  out  32  byte address of next fetch; data_seek  out  1  seek in progress.
REQ-013 data_req  out  1  one-cycle fetch request; data  in  8; data_ack  in  1  one-cycle pulse, data valid in the same cycle.

Function
REQ-014 MSU_SEL = ENABLE & !ADDR[22] & ADDR[15:4]==0x200 & !ADDR[3].
REQ-015 Writes are taken when MSU_SEL & SYSCLKF_CE & !WR_N: regs 0-2 hold seek bytes; reg 3 = seek MSB and triggers a seek; reg 4 = track LSB; reg 5 = track MSB, loads track_num and sets track_request; reg 6 = volume target; reg 7 = {repeat=DIN[1], playing=DIN[0]}.
REQ-016 track_request clears on the falling edge of track_mounting; status_audio_playing clears when audio_stop=1, and a reg 7 write in the same cycle takes priority.
REQ-017 Fetch FSM states: IDLE, REQ, WAIT. From IDLE, go to REQ when the FIFO is not full; REQ drives data_req=1 for exactly one cycle and then goes to WAIT; WAIT goes back to IDLE on data_ack. The FSM never has more than one request outstanding.
REQ-018 On data_ack (not stale), push data into the FIFO and set data_addr=data_addr+1, wrapping modulo 2^32.
REQ-019 A seek does all of the following in one cycle: load data_addr={DIN,seek[23:0]}, flush the FIFO, set data_seek=1, and return the FSM to IDLE. If a request is outstanding, its ack is marked stale and dropped without a push or increment.
REQ-020 data_seek clears on the first accepted push after a seek.
REQ-021 MSU_STATUS = {data_busy, track_request, repeat, playing, status_track_missing, 3'b010}, where data_busy = data_seek | FIFO empty.
REQ-022 A data read is MSU_SEL & !RD_N & ADDR[2:0]==1. On the falling edge of that condition, pop one FIFO entry if the FIFO is not empty; if empty, do nothing.
REQ-023 DOUT is registered every cycle from ADDR[2:0]: 0 = MSU_STATUS; 1 = FIFO head, or 0x00 when empty; 2..7 = "S","-","M","S","U","2".
REQ-024 If a push and a pop occur in the same cycle, the FIFO count is unchanged and head/tail pointers wrap modulo FIFO_DEPTH.
REQ-025 A seek in the same cycle as a pop or push gives the seek priority: the FIFO ends empty.

Reset
REQ-026 While RST_N=0 at a CLK edge, all of the following are cleared to 0: outputs (except MSU_SEL, which is combinational), seek/track shadow registers, FIFO pointers and count, stale flag, fade counter; the FSM goes to IDLE.
REQ-027 Reset mid-fetch discards the outstanding request; a data_ack arriving after reset is ignored until the FSM is in WAIT.

Configuration
REQ-028 Macro MSU_FADE_EN.
- Defined: volume steps by 1 toward the reg 6 target once every FADE_DIV cycles; a new target restarts the step counter.
- Undefined: volume = DIN immediately on a reg 6 write, and no fade counter is instantiated.

Verification
REQ-029 Seek write 0x00001000 with ack 2 cycles after each req -> data_seek=1, data_addr ends 0x1000+FIFO_DEPTH, status bit7 falls after the first push, exactly FIFO_DEPTH req pulses.
REQ-030 Fill FIFO with 0xA0..0xA7, then 8 reads of $2001 -> DOUT 0xA0..0xA7 in order, a refill req after each pop, and a 9th read returns the next fetched byte.
REQ-031 Seek issued while in WAIT, then ack with 0x55 -> 0x55 is not pushed, data_addr equals the new seek, and a new req follows.
REQ-032 Write 0x0102 to $2004/$2005 -> track_num=0x0102, track_request=1; pulse track_mounting 1->0 -> track_request=0.
REQ-033 With MSU_FADE_EN and FADE_DIV=4, write 0x03 to $2006 -> volume 0,1,2,3 at 4-cycle spacing; without the macro -> volume=0x03 on the next cycle.
REQ-034 Assert RST_N=0 during a pending fetch -> all outputs 0 the next cycle, FIFO empty, and a subsequent stray data_ack causes no push.
